// File: rtl/decoder_w_hold_if.sv
// Handshake/bus bundle for decoder_w_hold: request code in, one-hot lines and status out.
interface decoder_w_hold_if #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4
);
    logic             en;
    logic [IN_W-1:0]  a;
    logic             ready;
    logic             busy;
    logic [OUT_W-1:0] y;
    logic             done;
    logic             err;

    modport master (
        output en,
        output a,
        input  ready,
        input  busy,
        input  y,
        input  done,
        input  err
    );

    modport slave (
        input  en,
        input  a,
        output ready,
        output busy,
        output y,
        output done,
        output err
    );
endinterface

// File: rtl/decoder_w_hold.sv
// Registered binary-to-one-hot decoder; each accepted code drives its line for HOLD cycles.
// Optional out-of-range error pulse enabled by defining DECODER_ERR_DETECT_EN.
module decoder_w_hold #(
    parameter int unsigned IN_W  = 2,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned HOLD  = 3
) (
    input logic              clk,
    input logic              rst_n,
    decoder_w_hold_if.slave  bus
);
    localparam int unsigned CntW = $clog2(HOLD + 1);

`ifdef DECODER_ERR_DETECT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    state_t           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [OUT_W-1:0] y_q;
    logic             done_q;
    logic             err_q;
    logic [OUT_W-1:0] one_hot;
    logic             a_valid;

    // Lines only exist below OUT_W, so an empty decode means the code is out of range.
    always_comb begin
        one_hot = '0;
        for (int unsigned i = 0; i < OUT_W; i++) begin
            one_hot[i] = (bus.a == IN_W'(i));
        end
        a_valid = |one_hot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        if (a_valid) begin
                            y_q     <= one_hot;
                            cnt_q   <= CntW'(HOLD - 1);
                            state_q <= StHold;
                        end else begin
                            err_q <= ErrEn;
                        end
                    end
                end
                StHold: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CntW'(1);
                    end else begin
                        y_q     <= '0;
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.ready = (state_q == StIdle);
    assign bus.busy  = (state_q != StIdle);
    assign bus.y     = y_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_decoder_w_hold.sv
// Self-checking bench for decoder_w_hold: default, OUT_W=3 and HOLD=1 instances driven in parallel.
module tb_decoder_w_hold;
`ifdef DECODER_ERR_DETECT_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] a;

    int n_checks = 0;
    int n_fail   = 0;

    decoder_w_hold_if #(.IN_W(2), .OUT_W(4)) if_a ();
    decoder_w_hold_if #(.IN_W(2), .OUT_W(3)) if_b ();
    decoder_w_hold_if #(.IN_W(2), .OUT_W(4)) if_c ();

    assign if_a.en = en;
    assign if_a.a  = a;
    assign if_b.en = en;
    assign if_b.a  = a;
    assign if_c.en = en;
    assign if_c.a  = a;

    decoder_w_hold #(.IN_W(2), .OUT_W(4), .HOLD(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    decoder_w_hold #(.IN_W(2), .OUT_W(3), .HOLD(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    decoder_w_hold #(.IN_W(2), .OUT_W(4), .HOLD(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: remaining high cycles of the current line; y is high while remain > 0.
    typedef struct {
        int remain;
        int line;
        bit done;
        bit err;
    } model_t;

    model_t m_a, m_b, m_c;

    function automatic model_t next_model(model_t m, bit r, bit e, int code, int out_w, int hold);
        model_t n;
        n      = m;
        n.done = 1'b0;
        n.err  = 1'b0;
        if (!r) begin
            n.remain = 0;
            n.line   = 0;
        end else if (m.remain > 0) begin
            n.remain = m.remain - 1;
            if (n.remain == 0) n.done = 1'b1;
        end else if (e) begin
            if (code < out_w) begin
                n.remain = hold;
                n.line   = code;
            end else begin
                n.err = ErrEn;
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input model_t m, input logic [3:0] y,
                             input logic ready, input logic busy, input logic done,
                             input logic err);
        logic [3:0] exp_y;
        exp_y = (m.remain > 0) ? 4'(1 << m.line) : 4'd0;
        check({tag, "_y"}, 32'(y), 32'(exp_y));
        check({tag, "_ready"}, 32'(ready), 32'(m.remain == 0));
        check({tag, "_busy"}, 32'(busy), 32'(m.remain != 0));
        check({tag, "_done"}, 32'(done), 32'(m.done));
        check({tag, "_err"}, 32'(err), 32'(m.err));
        check({tag, "_onehot0"}, 32'($onehot0(y)), 32'd1);
    endtask

    // Inputs are stable from the previous negedge; advance one edge and compare all instances.
    task automatic step();
        m_a = next_model(m_a, rst_n, en, int'(a), 4, 3);
        m_b = next_model(m_b, rst_n, en, int'(a), 3, 3);
        m_c = next_model(m_c, rst_n, en, int'(a), 4, 1);
        @(posedge clk);
        @(negedge clk);
        check_dut("a", m_a, if_a.y, if_a.ready, if_a.busy, if_a.done, if_a.err);
        check_dut("b", m_b, {1'b0, if_b.y}, if_b.ready, if_b.busy, if_b.done, if_b.err);
        check_dut("c", m_c, if_c.y, if_c.ready, if_c.busy, if_c.done, if_c.err);
    endtask

    typedef struct {
        bit         rst_n;
        bit         en;
        logic [1:0] a;
        logic [3:0] y;
        bit         ready;
        bit         done;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit e, logic [1:0] c, logic [3:0] y, bit rd, bit d);
        vec_t v;
        v.rst_n = r;
        v.en    = e;
        v.a     = c;
        v.y     = y;
        v.ready = rd;
        v.done  = d;
        return v;
    endfunction

    initial begin
        m_a = '{0, 0, 1'b0, 1'b0};
        m_b = m_a;
        m_c = m_a;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 2'd0;

        // Each row: inputs held across one edge, dut_a outputs expected after it.
        vecs.push_back(mk(0, 1, 2, 4'b0000, 1, 0));  // reset with a pending request
        vecs.push_back(mk(0, 1, 2, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 1, 2, 4'b0100, 0, 0));  // single pulse a=2
        vecs.push_back(mk(1, 0, 0, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 1, 0, 4'b0001, 0, 0));  // sweep with en held
        vecs.push_back(mk(1, 1, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4'b0001, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 1, 1, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 1, 2, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 1, 2, 4'b0010, 0, 0));
        vecs.push_back(mk(1, 1, 2, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 1, 2, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 1, 3, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 1, 3, 4'b0100, 0, 0));
        vecs.push_back(mk(1, 1, 3, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 1, 3, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 1));
        vecs.push_back(mk(1, 1, 1, 4'b0010, 0, 0));  // reset on 2nd hold cycle
        vecs.push_back(mk(1, 0, 0, 4'b0010, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 0));
        vecs.push_back(mk(1, 1, 3, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b1000, 0, 0));
        vecs.push_back(mk(1, 0, 0, 4'b0000, 1, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            en    = vecs[i].en;
            a     = vecs[i].a;
            step();
            check($sformatf("vec%0d_y", i), 32'(if_a.y), 32'(vecs[i].y));
            check($sformatf("vec%0d_ready", i), 32'(if_a.ready), 32'(vecs[i].ready));
            check($sformatf("vec%0d_done", i), 32'(if_a.done), 32'(vecs[i].done));
        end

        // OUT_W=3 instance: code 3 is out of range.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        a     = 2'd3;
        step();
        check("oor_err", 32'(if_b.err), 32'(ErrEn));
        check("oor_y", 32'(if_b.y), 32'd0);
        check("oor_ready", 32'(if_b.ready), 32'd1);
        check("oor_done", 32'(if_b.done), 32'd0);
        en = 1'b0;
        step();
        check("oor_err_clear", 32'(if_b.err), 32'd0);
        check("oor_done_after", 32'(if_b.done), 32'd0);

        // HOLD=1 instance: a=0 held gives alternating line/done cycles.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        a     = 2'd0;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("h1_y%0d", i), 32'(if_c.y), (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("h1_done%0d", i), 32'(if_c.done), (i % 2 == 0) ? 32'd0 : 32'd1);
        end

        for (int i = 0; i < 500; i++) begin
            rst_n = ($urandom_range(0, 24) != 0);
            en    = ($urandom_range(0, 3) != 0);
            a     = 2'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
